// File: rtl/scr1_avl_mem_arbiter_if.sv
// Avalon-MM port bundle shared by the imem, dmem and memory sides of the arbiter.
//  master modport : issues address/read/write/writedata/byteenable, receives
//                   waitrequest/readdata/readdatavalid/response.
//  slave modport  : the mirror image, used where commands are received.
interface scr1_avl_mem_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic [ADDR_W-1:0]   address;
   logic                read;
   logic                write;
   logic [DATA_W-1:0]   writedata;
   logic [DATA_W/8-1:0] byteenable;
   logic                waitrequest;
   logic [DATA_W-1:0]   readdata;
   logic                readdatavalid;
   logic [1:0]          response;

   modport master (
      output address, read, write, writedata, byteenable,
      input  waitrequest, readdata, readdatavalid, response
   );

   modport slave (
      input  address, read, write, writedata, byteenable,
      output waitrequest, readdata, readdatavalid, response
   );
endinterface

// File: rtl/scr1_avl_mem_arbiter.sv
// Shares one Avalon-MM memory master between the SCR1 imem and dmem ports.
// Round-robin grant with zero added latency, held while the memory stalls; up to
// MAX_PEND pipelined reads, with an in-order tag FIFO steering each readdatavalid
// back to the port that issued the read.
//  cpu_clk, cpu_rst_n : clock, asynchronous active-low reset
//  imem, dmem         : slave-side Avalon ports from the core
//  mem                : master-side Avalon port to the memory interconnect
//  pend_cnt           : outstanding read count
//  err_unexp_rdv      : sticky flag, readdatavalid seen with no read outstanding
module scr1_avl_mem_arbiter #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned MAX_PEND = 4
) (
   input  logic                        cpu_clk,
   input  logic                        cpu_rst_n,
   scr1_avl_mem_arbiter_if.slave       imem,
   scr1_avl_mem_arbiter_if.slave       dmem,
   scr1_avl_mem_arbiter_if.master      mem,
   output logic [$clog2(MAX_PEND):0]   pend_cnt,
   output logic                        err_unexp_rdv
);
   localparam int unsigned PtrW = $clog2(MAX_PEND);
   localparam int unsigned CntW = PtrW + 1;

   typedef enum logic {OwnImem = 1'b0, OwnDmem = 1'b1} owner_e;
   typedef enum logic {StFree = 1'b0, StLock = 1'b1} state_e;

   state_e              state_q, state_d;
   owner_e              lock_owner_q, lock_owner_d;
   owner_e              last_gnt_q, last_gnt_d;
   logic [MAX_PEND-1:0] tag_q, tag_d;
   logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic                err_q, err_d;

   owner_e owner;
   logic   gnt_vld, elig_i, elig_d, room, pop, push, cmd, accept;
   logic   sel_read, sel_write, head_dmem;

   always_comb begin
      pop  = mem.readdatavalid & (cnt_q != '0);
      // A read returning this cycle frees a slot, so a full FIFO can still take a read.
      room = (cnt_q < CntW'(MAX_PEND)) | pop;
      // A simultaneous read+write is handled as a read.
      elig_i = imem.read ? room : imem.write;
      elig_d = dmem.read ? room : dmem.write;

      gnt_vld = 1'b0;
      owner   = lock_owner_q;
      if (state_q == StLock) begin
         gnt_vld = 1'b1;
      end else if (elig_i && elig_d) begin
         gnt_vld = 1'b1;
         owner   = (last_gnt_q == OwnImem) ? OwnDmem : OwnImem;
      end else if (elig_d) begin
         gnt_vld = 1'b1;
         owner   = OwnDmem;
      end else if (elig_i) begin
         gnt_vld = 1'b1;
         owner   = OwnImem;
      end

      sel_read  = (owner == OwnDmem) ? dmem.read  : imem.read;
      sel_write = (owner == OwnDmem) ? dmem.write : imem.write;

      mem.read       = gnt_vld & sel_read;
      mem.write      = gnt_vld & sel_write & ~sel_read;
      mem.address    = (owner == OwnDmem) ? dmem.address    : imem.address;
      mem.writedata  = (owner == OwnDmem) ? dmem.writedata  : imem.writedata;
      mem.byteenable = (owner == OwnDmem) ? dmem.byteenable : imem.byteenable;

      imem.waitrequest = ~(gnt_vld & (owner == OwnImem)) | mem.waitrequest;
      dmem.waitrequest = ~(gnt_vld & (owner == OwnDmem)) | mem.waitrequest;

      cmd    = mem.read | mem.write;
      accept = cmd & ~mem.waitrequest;
      push   = accept & mem.read;

      head_dmem          = tag_q[rd_ptr_q];
      imem.readdata      = mem.readdata;
      dmem.readdata      = mem.readdata;
      imem.readdatavalid = pop & ~head_dmem;
      dmem.readdatavalid = pop & head_dmem;
      imem.response      = (pop & ~head_dmem) ? mem.response : 2'b00;
      dmem.response      = (pop & head_dmem)  ? mem.response : 2'b00;
   end

   // Grant lock: a stalled command keeps the bus until memory takes it.
   always_comb begin
      state_d      = state_q;
      lock_owner_d = lock_owner_q;
      last_gnt_d   = last_gnt_q;
      if (accept) begin
         state_d    = StFree;
         last_gnt_d = owner;
      end else if (cmd) begin
         state_d      = StLock;
         lock_owner_d = owner;
      end else begin
         // Owner dropped its command: nothing left to hold the bus for.
         state_d = StFree;
      end
   end

   always_comb begin
      tag_d    = tag_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         tag_d[wr_ptr_q] = (owner == OwnDmem);
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      cnt_d = cnt_q + CntW'(push) - CntW'(pop);
      err_d = err_q | (mem.readdatavalid & (cnt_q == '0));
   end

   always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         state_q      <= StFree;
         lock_owner_q <= OwnImem;
         last_gnt_q   <= OwnImem;
         tag_q        <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         cnt_q        <= '0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         lock_owner_q <= lock_owner_d;
         last_gnt_q   <= last_gnt_d;
         tag_q        <= tag_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         cnt_q        <= cnt_d;
         err_q        <= err_d;
      end
   end

   assign pend_cnt      = cnt_q;
   assign err_unexp_rdv = err_q;
endmodule
